inv_key_expansion: RTL and testbench

INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

---
 rtl/inv_key_expansion.sv | 269 ++++++++++++++++++++++++++
 tb/tb_inv_key_expansion.sv | 532 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_expansion.sv
// ---------------------------------------------------------------------------
// inv_key_expansion
//
// Purpose:
//   Walks the AES-128 key schedule backwards.  A round key (round LAST_ROUND)
//   is loaded on start.  Each step recovers the previous round key.  Keys are
//   offered on a valid/ready handshake down to round 0.  A one-cycle done
//   pulse follows acceptance of the round-0 key.
//
// Parameters:
//   LAST_ROUND : round index of the loaded key (1..10)
//
// Ports:
//   clk      in   1    clock; all state changes on its rising edge
//   reset    in   1    synchronous active-high reset
//   start    in   1    load keyInput and begin; only honoured while idle
//   keyInput in   128  round-LAST_ROUND key, word0 = bits 127:96
//   keyReady in   1    consumer accepts keyOut this cycle
//   keyOut   out  128  recovered round key
//   keyNum   out  4    round index of keyOut
//   keyValid out  1    keyOut/keyNum hold a key not yet accepted
//   busy     out  1    schedule in progress
//   done     out  1    one-cycle pulse after the round-0 key is accepted
//
// Optional feature (macro INV_KEY_STORE_EN):
//   Adds an 11 x 128 key store holding every key seen in the run.  The store
//   is indexed by round number.  It adds two ports:
//   rdAddr   in   4    store read address
//   rdKey    out  128  store data, one cycle after rdAddr; 0 for rdAddr > 10
//   Reset does not clear the store.
// ---------------------------------------------------------------------------
module inv_key_expansion #(
  parameter int LAST_ROUND = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] keyInput,
  input  logic         keyReady,
`ifdef INV_KEY_STORE_EN
  input  logic [3:0]   rdAddr,
  output logic [127:0] rdKey,
`endif
  output logic [127:0] keyOut,
  output logic [3:0]   keyNum,
  output logic         keyValid,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_CNT = 4'(LAST_ROUND);

  // AES forward S-box, row-major by input byte.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Round constant used when round `round` was produced going forwards.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  state_t         state_reg, state_next;
  logic [127:0]   cur_key_reg, cur_key_next;
  logic [3:0]     cnt_reg, cnt_next;
  logic [127:0]   key_out_reg, key_out_next;
  logic [3:0]     key_num_reg, key_num_next;
  logic           key_valid_reg, key_valid_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;

  // ---------------------------------------------------------------------
  // Inverse step datapath
  // ---------------------------------------------------------------------
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [127:0] prev_key;
  logic [3:0]   cnt_minus_one;

  assign w0 = cur_key_reg[127:96];
  assign w1 = cur_key_reg[95:64];
  assign w2 = cur_key_reg[63:32];
  assign w3 = cur_key_reg[31:0];

  // Later words of a round key are running XORs, so neighbouring words
  // give back the earlier key's words 1..3 directly.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // Left byte rotation: the top byte moves to the bottom.
  assign rot_word = {p3[23:0], p3[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub_word
      assign sub_word[gi*8 +: 8] = SBOX[rot_word[gi*8 +: 8]];
    end
  endgenerate

  assign p0            = w0 ^ sub_word ^ {rcon(cnt_reg), 24'h0};
  assign prev_key      = {p0, p1, p2, p3};
  assign cnt_minus_one = cnt_reg - 4'd1;

  // ---------------------------------------------------------------------
  // Handshake events
  // ---------------------------------------------------------------------
  logic load_fire;
  logic step_fire;
  logic drain_fire;

  assign load_fire  = (state_reg == IDLE) && start;
  // A new key may replace the held one only when the slot is empty or the
  // held key is being taken this cycle.
  assign step_fire  = (state_reg == RUN) && (!key_valid_reg || keyReady);
  assign drain_fire = (state_reg == DRAIN) && key_valid_reg && keyReady;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cur_key_reg   <= '0;
      cnt_reg       <= '0;
      key_out_reg   <= '0;
      key_num_reg   <= '0;
      key_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_key_reg   <= cur_key_next;
      cnt_reg       <= cnt_next;
      key_out_reg   <= key_out_next;
      key_num_reg   <= key_num_next;
      key_valid_reg <= key_valid_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    cur_key_next   = cur_key_reg;
    cnt_next       = cnt_reg;
    key_out_next   = key_out_reg;
    key_num_next   = key_num_reg;
    key_valid_next = key_valid_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (load_fire) begin
          cur_key_next = keyInput;
          cnt_next     = LAST_CNT;
          busy_next    = 1'b1;
          state_next   = RUN;
        end
      end

      RUN: begin
        // Every accept in RUN is paired with a fresh key, so keyValid stays
        // high until the final key is taken in DRAIN.  A stalled key holds.
        if (step_fire) begin
          key_out_next   = prev_key;
          key_num_next   = cnt_minus_one;
          key_valid_next = 1'b1;
          cur_key_next   = prev_key;
          cnt_next       = cnt_minus_one;
          if (cnt_minus_one == 4'd0) begin
            state_next = DRAIN;
          end
        end
      end

      DRAIN: begin
        // Round-0 key is on the output; wait for it to be taken.
        if (drain_fire) begin
          key_valid_next = 1'b0;
          busy_next      = 1'b0;
          done_next      = 1'b1;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign keyOut   = key_out_reg;
  assign keyNum   = key_num_reg;
  assign keyValid = key_valid_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

`ifdef INV_KEY_STORE_EN
  // ---------------------------------------------------------------------
  // Key store: one write port (load or step, never both in a cycle) and a
  // registered read port.  Neither the contents nor the read register are
  // reset.  Contents survive an aborted run.
  // ---------------------------------------------------------------------
  logic [127:0] key_store [0:10];
  logic         store_we;
  logic [3:0]   store_addr;
  logic [127:0] store_data;
  logic [127:0] rd_key_reg;

  assign store_we   = !reset && (load_fire || step_fire);
  assign store_addr = load_fire ? LAST_CNT : cnt_minus_one;
  assign store_data = load_fire ? keyInput : prev_key;

  always_ff @(posedge clk) begin
    if (store_we) begin
      key_store[store_addr] <= store_data;
    end
    if (rdAddr <= 4'd10) begin
      rd_key_reg <= key_store[rdAddr];
    end else begin
      rd_key_reg <= '0;
    end
  end

  assign rdKey = rd_key_reg;
`endif

endmodule

// File: tb/tb_inv_key_expansion.sv
// ---------------------------------------------------------------------------
// tb_inv_key_expansion
//
// Self-checking bench for inv_key_expansion.  The reference model runs the
// AES-128 key schedule forwards from a cipher key.  Its S-box comes from
// GF(2^8) inversion plus the affine map.  The DUT must return that schedule
// in reverse.  Two instances are used: LAST_ROUND=10 and LAST_ROUND=1.
// The store check runs when INV_KEY_STORE_EN is defined.
// ---------------------------------------------------------------------------
module tb_inv_key_expansion;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] key_input;
  logic         key_ready;
  logic [127:0] key_out;
  logic [3:0]   key_num;
  logic         key_valid;
  logic         busy;
  logic         done;

  logic         start1;
  logic [127:0] key_input1;
  logic         key_ready1;
  logic [127:0] key_out1;
  logic [3:0]   key_num1;
  logic         key_valid1;
  logic         busy1;
  logic         done1;

`ifdef INV_KEY_STORE_EN
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
  logic [3:0]   rd_addr1;
  logic [127:0] rd_key1;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] rk [0:10];

  inv_key_expansion #(.LAST_ROUND(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .keyInput (key_input),
    .keyReady (key_ready),
`ifdef INV_KEY_STORE_EN
    .rdAddr   (rd_addr),
    .rdKey    (rd_key),
`endif
    .keyOut   (key_out),
    .keyNum   (key_num),
    .keyValid (key_valid),
    .busy     (busy),
    .done     (done)
  );

  inv_key_expansion #(.LAST_ROUND(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .start    (start1),
    .keyInput (key_input1),
    .keyReady (key_ready1),
`ifdef INV_KEY_STORE_EN
    .rdAddr   (rd_addr1),
    .rdKey    (rd_key1),
`endif
    .keyOut   (key_out1),
    .keyNum   (key_num1),
    .keyValid (key_valid1),
    .busy     (busy1),
    .done     (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] bv;
    for (int b = 0; b < 256; b++) begin
      bv  = 8'(b);
      inv = 8'h00;
      if (b != 0) begin
        for (int c = 1; c < 256; c++) begin
          if (gmul(bv, 8'(c)) == 8'h01) inv = 8'(c);
        end
      end
      sbox_m[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // Forward AES-128 expansion; rk[r] is the round-r key.
  task automatic expand_key(input logic [127:0] cipher_key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = cipher_key[127:96];
    w[1] = cipher_key[95:64];
    w[2] = cipher_key[63:32];
    w[3] = cipher_key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) begin
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    start1 = 1'b1;
    key_ready = 1'b1;
    key_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (key_out !== 128'h0 || key_num !== 4'h0 || key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%h num=%0d valid=%b busy=%b done=%b, want all 0",
               key_out, key_num, key_valid, busy, done);
    end
    checks++;
    if (key_out1 !== 128'h0 || key_num1 !== 4'h0 || key_valid1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_lr1: got out=%h num=%0d valid=%b busy=%b done=%b, want all 0",
               key_out1, key_num1, key_valid1, busy1, done1);
    end
    reset = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_beats_start: got busy=%b busy1=%b, want 0 0", busy, busy1);
    end
    $display("reset: outputs cleared, start under reset ignored");
  endtask

  task automatic test_known_vector();
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    key_ready = 1'b1;
    key_input = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (e <= 10) begin
        checks++;
        if (key_valid !== 1'b1 || key_num !== 4'(10 - e) || key_out !== rk[10 - e]) begin
          errors++;
          $display("FAIL known_seq edge %0d: got valid=%b num=%0d out=%h, want 1 %0d %h",
                   e, key_valid, key_num, key_out, 10 - e, rk[10 - e]);
        end else begin
          $display("known: key %0d = %h", key_num, key_out);
        end
      end
      if (e == 1) begin
        checks++;
        if (key_out !== 128'hac7766f319fadc2128d12941575c006e || key_num !== 4'd9) begin
          errors++;
          $display("FAIL known_first: got num=%0d out=%h, want 9 ac7766f319fadc2128d12941575c006e",
                   key_num, key_out);
        end
      end
      if (e == 10) begin
        checks++;
        if (key_out !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
          errors++;
          $display("FAIL known_round0: got %h, want 2b7e151628aed2a6abf7158809cf4f3c", key_out);
        end
      end
      checks++;
      if (done !== (e == 11)) begin
        errors++;
        $display("FAIL known_done edge %0d: got %b, want %b", e, done, (e == 11));
      end
    end
    checks++;
    if (busy !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL known_idle: got busy=%b valid=%b, want 0 0", busy, key_valid);
    end
  endtask

`ifdef INV_KEY_STORE_EN
  task automatic test_key_store();
    // rk still holds the schedule of the run just completed.
    rd_addr = 4'd9;
    @(posedge clk);
    #1;
    checks++;
    if (rd_key !== rk[9]) begin
      errors++;
      $display("FAIL store_rd9: got %h, want %h", rd_key, rk[9]);
    end
    rd_addr = 4'd12;
    @(posedge clk);
    #1;
    checks++;
    if (rd_key !== 128'h0) begin
      errors++;
      $display("FAIL store_rd12: got %h, want 0", rd_key);
    end
    reset = 1'b1;
    rd_addr = 4'd10;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_addr = 4'd0;
    @(posedge clk);
    #1;
    checks++;
    if (rd_key !== rk[0]) begin
      errors++;
      $display("FAIL store_after_reset: got %h, want %h", rd_key, rk[0]);
    end
    $display("store: reads of 9, 12 and 0 after reset done");
  endtask
`endif

  task automatic test_stall();
    bit seen;
    expand_key(rand128());
    key_ready = 1'b1;
    key_input = rk[10];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (key_valid === 1'b1 && key_num === 4'd5) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_reach5: keyNum 5 not seen within 20 cycles, got num=%0d", key_num);
    end
    key_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (key_valid !== 1'b1 || key_num !== 4'd5 || key_out !== rk[5] || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold %0d: got valid=%b num=%0d out=%h done=%b, want 1 5 %h 0",
                 c, key_valid, key_num, key_out, done, rk[5]);
      end
    end
    key_ready = 1'b1;
    for (int k = 4; k >= 0; k--) begin
      @(posedge clk);
      #1;
      checks++;
      if (key_valid !== 1'b1 || key_num !== 4'(k) || key_out !== rk[k]) begin
        errors++;
        $display("FAIL stall_resume: got valid=%b num=%0d out=%h, want 1 %0d %h",
                 key_valid, key_num, key_out, k, rk[k]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: got %b, want 1", done);
    end
    $display("stall: 3-cycle hold at key 5, resumed 4..0");
  endtask

  task automatic test_random_runs();
    bit           finished;
    bit           acc;
    bit           kv_s;
    logic [3:0]   num_s;
    logic [127:0] out_s;
    int           exp_idx;
    for (int run = 0; run < 8; run++) begin
      expand_key(rand128());
      key_input = rk[10];
      key_ready = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_idx = 9;
      finished = 1'b0;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
        key_ready = ($urandom_range(0, 3) != 0);
        // Stray start requests during the run (including the done edge).
        start = ($urandom_range(0, 3) == 0);
        key_input = rand128();
        kv_s  = key_valid;
        num_s = key_num;
        out_s = key_out;
        acc   = kv_s && key_ready;
        @(posedge clk);
        #1;
        if (acc) begin
          checks++;
          if (num_s !== exp_idx[3:0] || out_s !== rk[exp_idx]) begin
            errors++;
            $display("FAIL rand_key run %0d: got num=%0d out=%h, want %0d %h",
                     run, num_s, out_s, exp_idx, rk[exp_idx]);
          end else begin
            $display("rand run %0d: key %0d = %h", run, num_s, out_s);
          end
        end else if (kv_s) begin
          checks++;
          if (key_valid !== 1'b1 || key_num !== num_s || key_out !== out_s) begin
            errors++;
            $display("FAIL rand_hold run %0d: got valid=%b num=%0d out=%h, want 1 %0d %h",
                     run, key_valid, key_num, key_out, num_s, out_s);
          end
        end
        checks++;
        if (done !== (acc && exp_idx == 0)) begin
          errors++;
          $display("FAIL rand_done run %0d: got %b, want %b", run, done, (acc && exp_idx == 0));
        end
        if (acc) begin
          if (exp_idx == 0) begin
            finished = 1'b1;
            checks++;
            if (busy !== 1'b0 || key_valid !== 1'b0) begin
              errors++;
              $display("FAIL rand_end run %0d: got busy=%b valid=%b, want 0 0", run, busy, key_valid);
            end
          end else begin
            exp_idx--;
          end
        end
      end
      start = 1'b0;
      if (!finished) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout run %0d: stuck at key %0d, want completion", run, exp_idx);
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle run %0d: got busy=%b done=%b, want 0 0", run, busy, done);
      end
    end
  endtask

  task automatic test_abort();
    bit seen;
    expand_key(rand128());
    key_ready = 1'b1;
    key_input = rk[10];
    start = 1'b1;
    @(posedge clk);
    #1;
    key_input = rand128();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (key_valid !== 1'b1 || key_out !== rk[key_num]) begin
        errors++;
        $display("FAIL abort_midrun_start: got valid=%b num=%0d out=%h, want 1 %h",
                 key_valid, key_num, key_out, rk[key_num]);
      end
      if (key_num === 4'd3) seen = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (key_out !== 128'h0 || key_num !== 4'h0 || key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: got out=%h num=%0d valid=%b busy=%b done=%b, want all 0",
               key_out, key_num, key_valid, busy, done);
    end
    reset = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || key_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet: got done=%b valid=%b busy=%b, want 0 0 0", done, key_valid, busy);
      end
    end
    key_input = rk[10];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (key_valid !== 1'b1 || key_num !== 4'd9 || key_out !== rk[9]) begin
      errors++;
      $display("FAIL abort_restart: got valid=%b num=%0d out=%h, want 1 9 %h",
               key_valid, key_num, key_out, rk[9]);
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort_restart_done: no done within 20 cycles, got busy=%b", busy);
    end
    $display("abort: reset at key 3, restart from round 10");
  endtask

  task automatic test_last_round1();
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    key_input1 = 128'ha0fafe1788542cb123a339392a6c7605;
    key_ready1 = 1'b0;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (key_valid1 !== 1'b1 || key_num1 !== 4'd0 || key_out1 !== rk[0] || done1 !== 1'b0) begin
      errors++;
      $display("FAIL lr1_key: got valid=%b num=%0d out=%h done=%b, want 1 0 %h 0",
               key_valid1, key_num1, key_out1, done1, rk[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (key_valid1 !== 1'b1 || key_out1 !== rk[0] || done1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL lr1_hold: got valid=%b out=%h done=%b busy=%b, want 1 %h 0 1",
               key_valid1, key_out1, done1, busy1, rk[0]);
    end
    key_ready1 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (done1 !== 1'b1 || key_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL lr1_done: got done=%b valid=%b busy=%b, want 1 0 0", done1, key_valid1, busy1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done1 !== 1'b0) begin
      errors++;
      $display("FAIL lr1_done_pulse: got %b, want 0", done1);
    end
    $display("last_round1: key 0 = %h", rk[0]);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    key_input = '0;
    key_ready = 1'b0;
    start1 = 1'b0;
    key_input1 = '0;
    key_ready1 = 1'b0;
`ifdef INV_KEY_STORE_EN
    rd_addr = 4'd0;
    rd_addr1 = 4'd0;
`endif
    build_sbox();
    test_reset();
    test_known_vector();
`ifdef INV_KEY_STORE_EN
    test_key_store();
`endif
    test_stall();
    test_random_runs();
    test_abort();
    test_last_round1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
